// File: rtl/bcd_display_pkg.sv
// Shared segment encodings (active-low form) and sizing helpers for the BCD scan display.
package bcd_display_pkg;

  //                                   gfedcba
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Prescaler width; never below one bit even for the minimum divide of 2.
  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Invalid codes 10..15 show a dash so a corrupted counter stage is visible.
module bcd_to_seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment driver: shadow-captures BCD digits and scans LSD->MSD.
// Outputs registered: 1 cycle after a digit-index change, 2 edges from load to segments.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  scan_tick
);

  localparam int                CNT_W   = cnt_width(SCAN_DIV);
  localparam int                IDX_W   = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic              INV     = ~ACTIVE_LOW;

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0][3:0]       shadow_q, shadow_d;
  logic [DIGITS-1:0]            sdp_q, sdp_d;
  logic                         tick_q, tick_d;
  logic [DIGITS-1:0]            an_q, an_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;

  logic                         cnt_wrap;
  logic                         upper_zero;
  logic                         blanked;
  logic                         cur_dp;
  logic [3:0]                   cur_digit;
  logic [6:0]                   dec_seg;
  logic [DIGITS-1:0]            an_lo;

  always_comb begin
    cnt_wrap = (cnt_q == CNT_MAX);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    tick_d   = (cnt_d == CNT_MAX);
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    shadow_d = load ? bcd_in : shadow_q;
    sdp_d    = load ? dp_in  : sdp_q;
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_q) && shadow_q[k] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign cur_digit = shadow_q[idx_q];
  assign cur_dp    = sdp_q[idx_q];
  assign blanked   = blank_lz && (idx_q != '0) && upper_zero;

  bcd_to_seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Built in active-low form, then flipped as a whole for active-high boards.
  always_comb begin
    an_lo = ~(DIGITS'(1) << idx_q);
    if (blanked && !cur_dp) begin
      an_lo = '1;
    end
    an_d  = an_lo ^ {DIGITS{INV}};
    seg_d = (blanked ? SEG_OFF : dec_seg) ^ {7{INV}};
    dp_d  = ~cur_dp ^ INV;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      tick_q   <= 1'b0;
      an_q     <= {DIGITS{ACTIVE_LOW}};
      seg_q    <= {7{ACTIVE_LOW}};
      dp_q     <= ACTIVE_LOW;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      tick_q   <= tick_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: fixed vectors, corner sequences and random traffic vs a slot model.
module tb_bcd_display_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, tick, tick2;

  int          tests = 0;
  int          fails = 0;
  int          n;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;

  always #5 clock = ~clock;

  bcd_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .scan_tick(tick)
  );

  bcd_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b0)) dut_hi (
    .clock(clock), .reset_n(reset_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .an(an2), .seg(seg2), .dp(dp2), .scan_tick(tick2)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic        bl;
    int          k;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Active-low picture of one slot from the captured digits.
  task automatic model_out(input int idx, input logic [15:0] sh, input logic [3:0] dpm,
                           input logic bl, output logic [3:0] ea, output logic [6:0] es,
                           output logic ed);
    logic [15:0] up;
    logic        blk;
    up  = sh >> (4 * idx);
    blk = bl && (idx > 0) && (up == 16'h0);
    ea  = (blk && !dpm[idx]) ? 4'hF : ~(4'b0001 << idx);
    es  = blk ? 7'h7F : seg_of(int'(up[3:0]));
    ed  = ~dpm[idx];
  endtask

  task automatic step();
    logic [3:0] ea, ea_hi;
    logic [6:0] es, es_hi;
    logic       ed, ed_hi, et;
    int         idx;
    idx = (n / SCAN_DIV) % DIGITS;
    model_out(idx, m_sh, m_dp, blank_lz, ea, es, ed);
    if (load) begin
      m_sh = bcd_in;
      m_dp = dp_in;
    end
    n++;
    et = ((n % SCAN_DIV) == SCAN_DIV - 1);
    ea_hi = ~ea;
    es_hi = ~es;
    ed_hi = ~ed;
    @(posedge clock);
    #1;
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("dp", dp, ed);
    chk("tick", tick, et);
    chk("an_hi", an2, ea_hi);
    chk("seg_hi", seg2, es_hi);
    chk("dp_hi", dp2, ed_hi);
    chk("tick_hi", tick2, et);
  endtask

  // Called just after a rising edge; release lands on the falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_tick", tick, 1'b0);
    chk("rst_an_hi", an2, 4'h0);
    chk("rst_seg_hi", seg2, 7'h00);
    chk("rst_dp_hi", dp2, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    n    = 0;
    m_sh = 16'h0;
    m_dp = 4'h0;
  endtask

  initial begin
    reset_n  = 1'b0;
    bcd_in   = 16'h0;
    dp_in    = 4'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
    n        = 0;
    m_sh     = 16'h0;
    m_dp     = 4'h0;

    vt.push_back('{16'h1234, 4'b0000, 1'b0, 0, 4'b1110, 7'b0011001, 1'b1});
    vt.push_back('{16'h1234, 4'b0000, 1'b0, 1, 4'b1101, 7'b0110000, 1'b1});
    vt.push_back('{16'h1234, 4'b0000, 1'b0, 2, 4'b1011, 7'b0100100, 1'b1});
    vt.push_back('{16'h1234, 4'b0000, 1'b0, 3, 4'b0111, 7'b1111001, 1'b1});
    vt.push_back('{16'h0040, 4'b0000, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0040, 4'b0000, 1'b1, 2, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0040, 4'b0000, 1'b1, 1, 4'b1101, 7'b0011001, 1'b1});
    vt.push_back('{16'h0040, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1});
    vt.push_back('{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1});
    vt.push_back('{16'h0000, 4'b0000, 1'b1, 1, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h00A0, 4'b0000, 1'b0, 1, 4'b1101, 7'b0111111, 1'b1});
    vt.push_back('{16'h00A0, 4'b0010, 1'b0, 1, 4'b1101, 7'b0111111, 1'b0});
    vt.push_back('{16'h00A0, 4'b0010, 1'b0, 0, 4'b1110, 7'b1000000, 1'b1});
    vt.push_back('{16'h0000, 4'b0100, 1'b1, 2, 4'b1011, 7'b1111111, 1'b0});
    vt.push_back('{16'h8888, 4'b0000, 1'b0, 2, 4'b1011, 7'b0000000, 1'b1});

    @(posedge clock);
    #1;
    do_reset();

    // Reset mid-slot, then the first slot after release must last a full SCAN_DIV cycles.
    bcd_in = 16'h1234;
    load   = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t1_an", an, (i <= 4) ? 4'b1110 : 4'b1101);
    end

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clock);
      #1;
      do_reset();
      bcd_in   = vt[i].bcd;
      dp_in    = vt[i].dpv;
      blank_lz = vt[i].bl;
      load     = 1'b1;
      step();
      load = 1'b0;
      while (n < SCAN_DIV * vt[i].k + 2) step();
      chk($sformatf("vec%0d_an", i), an, vt[i].e_an);
      chk($sformatf("vec%0d_seg", i), seg, vt[i].e_seg);
      chk($sformatf("vec%0d_dp", i), dp, vt[i].e_dp);
    end

    // Load coinciding with the slot-boundary edge.
    do_reset();
    blank_lz = 1'b0;
    dp_in    = 4'h0;
    bcd_in   = 16'h1234;
    load     = 1'b1;
    step();
    load = 1'b0;
    while ((n % SCAN_DIV) != SCAN_DIV - 1) step();
    chk("t5_tick", tick, 1'b1);
    bcd_in = 16'h9999;
    load   = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_seg9", seg, 7'b0010000);
    end

    // Active-high instance: one-hot anodes, all segments lit for 8.
    do_reset();
    bcd_in = 16'h8888;
    load   = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t6_seg_hi", seg2, 7'h7F);
      chk("t6_an_hi", an2, 4'b0001 << (((n - 1) / SCAN_DIV) % DIGITS));
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      load = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < DIGITS; d++) begin
        bcd_in[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
